// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the drive requesters and the bus arbiter.
// master = arbiter side (drives grants), slave = requester side.
interface bus_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0] REQ;
  logic [NREQ-1:0] GRANT;
  logic [IDW-1:0]  GRANT_ID;
  logic            BUS_BUSY;
  logic            TURN;
  logic            TIMEOUT;

  modport master (
    input  REQ,
    output GRANT,
    output GRANT_ID,
    output BUS_BUSY,
    output TURN,
    output TIMEOUT
  );

  modport slave (
    output REQ,
    input  GRANT,
    input  GRANT_ID,
    input  BUS_BUSY,
    input  TURN,
    input  TIMEOUT
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin owner selection for the shared bidirectional data bus, with one dead cycle between owners.
// Optional forced revoke after HOLD_MAX owned cycles when BUS_ARB_TIMEOUT_EN is defined.
//
// state   | meaning
// S_IDLE  | no owner, arbitrate on any request
// S_OWNED | GRANT_ID drives the bus while its request stays high
// S_TURN  | one dead cycle, all drivers off, then arbitrate
module bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int HOLD_MAX = 16
) (
  input  logic          CLOCK,
  input  logic          RESET,
  bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWNED = 2'd1,
    S_TURN  = 2'd2
  } state_e;

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("bus_arbiter: NREQ out of range 2..8");
  end
  if (IDW != $clog2(NREQ)) begin : g_bad_idw
    $error("bus_arbiter: IDW must equal clog2(NREQ)");
  end
  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold
    $error("bus_arbiter: HOLD_MAX out of range 2..255");
  end

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            turn_q, turn_d;
  logic            timeout_q, timeout_d;
  logic            busy_q;

  logic            pick_valid;
  logic [IDW-1:0]  pick_idx;
  logic            owner_req;
  logic            hold_expired;

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Search starts just after the previous owner so it becomes lowest priority.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!pick_valid && bus.REQ[wrap_idx(last_q, k)]) begin
        pick_valid = 1'b1;
        pick_idx   = wrap_idx(last_q, k);
      end
    end
  end

  assign owner_req = bus.REQ[id_q];

`ifdef BUS_ARB_TIMEOUT_EN
  assign hold_expired = (cnt_q == 8'(HOLD_MAX - 1));
`else
  assign hold_expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    id_d      = id_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    turn_d    = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      S_IDLE, S_TURN: begin
        grant_d = '0;
        state_d = S_IDLE;
        if (pick_valid) begin
          state_d = S_OWNED;
          grant_d = NREQ'(1) << pick_idx;
          id_d    = pick_idx;
          last_d  = pick_idx;
          cnt_d   = '0;
        end
      end
      S_OWNED: begin
        if (owner_req && !hold_expired) begin
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end else begin
          state_d   = S_TURN;
          grant_d   = '0;
          turn_d    = 1'b1;
          timeout_d = owner_req && hold_expired;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      id_q      <= '0;
      last_q    <= IDW'(NREQ - 1);
      cnt_q     <= '0;
      turn_q    <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      id_q      <= id_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      turn_q    <= turn_d;
      timeout_q <= timeout_d;
      busy_q    <= |grant_d;
    end
  end

  assign bus.GRANT    = grant_q;
  assign bus.GRANT_ID = id_q;
  assign bus.BUS_BUSY = busy_q;
  assign bus.TURN     = turn_q;
  assign bus.TIMEOUT  = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a per-cycle owner model predicts outputs, a negedge monitor compares.
module tb_bus_arbiter;
  localparam int N    = 4;
  localparam int HOLD = 4;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [N-1:0] grant;
    logic [1:0]   id;
    logic         busy;
    logic         turn;
    logic         to;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bus_arbiter_if #(.NREQ(N), .IDW(2)) bus_if ();

  bus_arbiter #(.NREQ(N), .IDW(2), .HOLD_MAX(HOLD)) dut (
    .CLOCK(clk),
    .RESET(rst_n),
    .bus  (bus_if.master)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: owner index (-1 = none), cycles owned so far, last winner.
  int   m_owner = -1;
  int   m_id    = 0;
  int   m_last  = N - 1;
  int   m_held  = 0;
  bit   m_turn  = 1'b0;
  bit   m_to    = 1'b0;

  task automatic model_step(input logic [N-1:0] rq, input logic rs);
    exp_t e;
    m_turn = 1'b0;
    m_to   = 1'b0;
    if (!rs) begin
      m_owner = -1;
      m_id    = 0;
      m_last  = N - 1;
      m_held  = 0;
    end else if (m_owner >= 0) begin
      if (rq[m_owner] && !(TO_EN && m_held == HOLD)) begin
        m_held++;
      end else begin
        m_to    = rq[m_owner];
        m_owner = -1;
        m_turn  = 1'b1;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (m_owner < 0 && rq[c]) begin
          m_owner = c;
          m_id    = c;
          m_last  = c;
          m_held  = 1;
        end
      end
    end
    e.grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    e.id    = 2'(m_id);
    e.busy  = (m_owner >= 0);
    e.turn  = m_turn;
    e.to    = m_to;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic [N-1:0] rq, input logic rs);
    bus_if.REQ = rq;
    rst_n      = rs;
    @(posedge clk);
    model_step(rq, rs);
    #1;
  endtask

  logic [N-1:0] prev_grant = '0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (bus_if.GRANT !== e.grant) begin
        errors++;
        $display("FAIL grant @%0t: got %b expected %b", $time, bus_if.GRANT, e.grant);
      end
      checks++;
      if (bus_if.GRANT_ID !== e.id) begin
        errors++;
        $display("FAIL grant_id @%0t: got %0d expected %0d", $time, bus_if.GRANT_ID, e.id);
      end
      checks++;
      if (bus_if.BUS_BUSY !== e.busy) begin
        errors++;
        $display("FAIL bus_busy @%0t: got %b expected %b", $time, bus_if.BUS_BUSY, e.busy);
      end
      checks++;
      if (bus_if.TURN !== e.turn) begin
        errors++;
        $display("FAIL turn @%0t: got %b expected %b", $time, bus_if.TURN, e.turn);
      end
      checks++;
      if (bus_if.TIMEOUT !== e.to) begin
        errors++;
        $display("FAIL timeout @%0t: got %b expected %b", $time, bus_if.TIMEOUT, e.to);
      end
      // Structural invariants, independent of the model.
      checks++;
      if (!$onehot0(bus_if.GRANT) || (bus_if.BUS_BUSY !== |bus_if.GRANT)) begin
        errors++;
        $display("FAIL onehot_busy @%0t: grant %b busy %b", $time, bus_if.GRANT, bus_if.BUS_BUSY);
      end
      checks++;
      if (prev_grant != '0 && bus_if.GRANT != '0 && prev_grant != bus_if.GRANT) begin
        errors++;
        $display("FAIL no_turnaround @%0t: prev %b now %b", $time, prev_grant, bus_if.GRANT);
      end
      prev_grant = bus_if.GRANT;
    end
  end

  initial begin
    logic [N-1:0] rq;
    bus_if.REQ = '0;
    rst_n      = 1'b0;

    // Single requester 2, then release.
    cyc('0, 1'b0);
    cyc('0, 1'b0);
    cyc('0, 1'b1);
    repeat (4) cyc(4'b0100, 1'b1);
    repeat (3) cyc('0, 1'b1);

    // All requesting; each owner drops for one cycle after 3 owned cycles.
    cyc('0, 1'b0);
    repeat (40) begin
      rq = 4'b1111;
      if (m_owner >= 0 && m_held == 3) rq[m_owner] = 1'b0;
      cyc(rq, 1'b1);
    end

    // Late request from 3 does not preempt owner 0.
    cyc('0, 1'b0);
    repeat (5) cyc(4'b0001, 1'b1);
    repeat (5) cyc(4'b1001, 1'b1);
    repeat (5) cyc(4'b1000, 1'b1);
    repeat (2) cyc('0, 1'b1);

    // Reset mid-ownership of requester 1.
    cyc('0, 1'b0);
    repeat (4) cyc(4'b0010, 1'b1);
    cyc(4'b0010, 1'b0);
    repeat (3) cyc(4'b0010, 1'b1);

    // Two requesters held constantly: timeout alternation or indefinite hold.
    cyc('0, 1'b0);
    repeat (100) cyc(4'b0011, 1'b1);

    // Randomised: slowly toggling request bits, rare resets.
    cyc('0, 1'b0);
    rq = '0;
    repeat (2000) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
      end
      cyc(rq, ($urandom_range(0, 199) != 0));
    end
    cyc('0, 1'b1);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
